// File: rtl/ltpi_data_channel_fifo_pkg.sv
// ltpi_data_channel_fifo_pkg: shared sizing helpers and parameter checks for the LTPI data channel FIFO bank
package ltpi_data_channel_fifo_pkg;
  function automatic int lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
  function automatic int slice_lo(input int ch, input int width);
    return ch * width;
  endfunction
  function automatic bit params_ok(input int depth, input int afull_th);
    return depth >= 2 && (depth & (depth - 1)) == 0 && afull_th >= 1 && afull_th <= depth;
  endfunction
endpackage

// File: rtl/ltpi_data_channel_fifo_ch.sv
// ltpi_data_channel_fifo_ch: one show-ahead FIFO channel with level, almost-full and sticky error flags
module ltpi_data_channel_fifo_ch
  import ltpi_data_channel_fifo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AFULL_TH = DEPTH - 4,
  parameter int LVL_W    = lvl_w(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_req,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_req,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic             almost_full,
  output logic [LVL_W-1:0] level,
  input  logic             flush,
  input  logic             clr_err,
  output logic             overflow,
  output logic             underflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic ovf_q, ovf_d, unf_q, unf_d, push, pop;
  assign empty       = level_q == '0;
  assign full        = level_q == LVL_W'(DEPTH);
  assign almost_full = level_q >= LVL_W'(AFULL_TH);
  assign level       = level_q;
  assign overflow    = ovf_q;
  assign underflow   = unf_q;
  assign rd_data     = empty ? '0 : mem[rd_ptr_q];
  // a pop frees the slot a full push needs, so both are accepted together
  always_comb begin
    push     = wr_req & (!full | rd_req);
    pop      = rd_req & !empty;
    wr_ptr_d = flush ? '0 : wr_ptr_q + AW'(push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + AW'(pop);
    level_d  = flush ? '0 : level_q + LVL_W'(push) - LVL_W'(pop);
    ovf_d    = (wr_req & full & !rd_req) | (ovf_q & !clr_err);
    unf_d    = (rd_req & empty) | (unf_q & !clr_err);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push && !flush && !reset) mem[wr_ptr_q] <= wr_data;
  end
endmodule

// File: rtl/ltpi_data_channel_fifo_bank.sv
// ltpi_data_channel_fifo_bank: NUM_CH independent FIFO channels behind packed per-channel buses
module ltpi_data_channel_fifo_bank
  import ltpi_data_channel_fifo_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int AFULL_TH = DEPTH - 4,
  localparam int LVL_W   = lvl_w(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       wr_req,
  input  logic [NUM_CH*WIDTH-1:0] wr_data,
  input  logic [NUM_CH-1:0]       rd_req,
  output logic [NUM_CH*WIDTH-1:0] rd_data,
  output logic [NUM_CH-1:0]       empty,
  output logic [NUM_CH-1:0]       full,
  output logic [NUM_CH-1:0]       almost_full,
  output logic [NUM_CH*LVL_W-1:0] level,
  input  logic [NUM_CH-1:0]       flush,
  input  logic [NUM_CH-1:0]       clr_err,
  output logic [NUM_CH-1:0]       overflow,
  output logic [NUM_CH-1:0]       underflow
);
  if (!params_ok(DEPTH, AFULL_TH) || NUM_CH < 1)
    $error("ltpi_data_channel_fifo_bank: bad NUM_CH/DEPTH/AFULL_TH");
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    ltpi_data_channel_fifo_ch #(
      .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH), .LVL_W(LVL_W)
    ) u_ch (
      .clk(clk),
      .reset(reset),
      .wr_req(wr_req[c]),
      .wr_data(wr_data[slice_lo(c, WIDTH) +: WIDTH]),
      .rd_req(rd_req[c]),
      .rd_data(rd_data[slice_lo(c, WIDTH) +: WIDTH]),
      .empty(empty[c]),
      .full(full[c]),
      .almost_full(almost_full[c]),
      .level(level[slice_lo(c, LVL_W) +: LVL_W]),
      .flush(flush[c]),
      .clr_err(clr_err[c]),
      .overflow(overflow[c]),
      .underflow(underflow[c])
    );
  end
endmodule

// File: tb/tb_ltpi_data_channel_fifo_bank.sv
// tb_ltpi_data_channel_fifo_bank: directed and random stimulus against a queue-based FIFO model
module tb_ltpi_data_channel_fifo_bank;
  localparam int NC = 2, W = 32, D = 8, AF = 6, LW = 4;
  logic clk = 1'b0, reset = 1'b1;
  logic [NC-1:0] wr_req = '0, rd_req = '0, flush = '0, clr_err = '0;
  logic [NC*W-1:0] wr_data = '0;
  logic [NC*W-1:0] rd_data;
  logic [NC-1:0] empty, full, almost_full, overflow, underflow;
  logic [NC*LW-1:0] level;
  int total = 0, bad = 0;
  logic [W-1:0] mq [NC][$];
  bit m_ovf [NC], m_unf [NC];
  ltpi_data_channel_fifo_bank #(.NUM_CH(NC), .WIDTH(W), .DEPTH(D), .AFULL_TH(AF)) dut (
    .clk(clk), .reset(reset), .wr_req(wr_req), .wr_data(wr_data), .rd_req(rd_req),
    .rd_data(rd_data), .empty(empty), .full(full), .almost_full(almost_full),
    .level(level), .flush(flush), .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_edge();
    for (int c = 0; c < NC; c++) begin
      int n;
      bit ovf_ev, unf_ev;
      n = mq[c].size();
      if (reset) begin
        mq[c].delete();
        m_ovf[c] = 0;
        m_unf[c] = 0;
        continue;
      end
      ovf_ev = wr_req[c] && n == D && !rd_req[c];
      unf_ev = rd_req[c] && n == 0;
      if (flush[c]) mq[c].delete();
      else begin
        if (rd_req[c] && n > 0) void'(mq[c].pop_front());
        if (wr_req[c] && (n < D || rd_req[c])) mq[c].push_back(wr_data[c*W +: W]);
      end
      m_ovf[c] = ovf_ev || (m_ovf[c] && !clr_err[c]);
      m_unf[c] = unf_ev || (m_unf[c] && !clr_err[c]);
    end
  endtask
  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      int n;
      string s;
      n = mq[c].size();
      s = $sformatf("ch%0d", c);
      chk({s, ".rd_data"}, rd_data[c*W +: W], n > 0 ? mq[c][0] : 32'h0);
      chk({s, ".level"}, 32'(level[c*LW +: LW]), 32'(n));
      chk({s, ".empty"}, 32'(empty[c]), 32'(n == 0));
      chk({s, ".full"}, 32'(full[c]), 32'(n == D));
      chk({s, ".afull"}, 32'(almost_full[c]), 32'(n >= AF));
      chk({s, ".ovf"}, 32'(overflow[c]), 32'(m_ovf[c]));
      chk({s, ".unf"}, 32'(underflow[c]), 32'(m_unf[c]));
    end
  endtask
  task automatic cyc(input logic [1:0] w, input logic [1:0] r, input logic [1:0] f,
                     input logic [1:0] ce, input logic [31:0] d0, input logic [31:0] d1,
                     input logic rs);
    @(negedge clk);
    wr_req = w; rd_req = r; flush = f; clr_err = ce; wr_data = {d1, d0}; reset = rs;
    @(posedge clk);
    model_edge();
    #1 compare_all();
  endtask
  initial begin
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 8; i++) cyc(2'b01, 0, 0, 0, 32'h100 + 32'(i), 0, 0);
    chk("fill.full", 32'(full[0]), 1);
    for (int i = 0; i < 8; i++) begin
      chk("drain.data", rd_data[31:0], 32'h100 + 32'(i));
      cyc(0, 2'b01, 0, 0, 0, 0, 0);
    end
    chk("drain.empty", 32'(empty[0]), 1);
    chk("ch1.empty", 32'(empty[1]), 1);
    for (int i = 0; i < 8; i++) cyc(2'b01, 0, 0, 0, 32'h200 + 32'(i), 0, 0);
    cyc(2'b01, 0, 0, 0, 32'hDEAD, 0, 0);
    chk("ovf.set", 32'(overflow[0]), 1);
    cyc(0, 0, 0, 2'b01, 0, 0, 0);
    chk("ovf.clr", 32'(overflow[0]), 0);
    cyc(2'b01, 2'b01, 0, 0, 32'hA, 0, 0);
    chk("fullpp.level", 32'(level[3:0]), 8);
    for (int i = 0; i < 8; i++) cyc(0, 2'b01, 0, 0, 0, 0, 0);
    cyc(2'b01, 2'b01, 0, 0, 32'hA, 0, 0);
    chk("emptypp.unf", 32'(underflow[0]), 1);
    chk("emptypp.data", rd_data[31:0], 32'hA);
    cyc(0, 0, 0, 2'b01, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(2'b01, 0, 0, 0, $urandom, 0, 0);
    for (int i = 0; i < 20; i++) begin
      int n;
      logic w, r;
      n = mq[0].size();
      w = n <= 5 ? 1'b1 : n >= 7 ? 1'($urandom_range(0, 1)) : 1'($urandom_range(0, 1));
      r = n >= 7 ? 1'b1 : n <= 5 ? 1'($urandom_range(0, 1)) & w : 1'($urandom_range(0, 1));
      cyc({1'b0, w}, {1'b0, r}, 0, 0, $urandom, 0, 0);
    end
    while (mq[0].size() > 5) cyc(0, 2'b01, 0, 0, 0, 0, 0);
    while (mq[0].size() < 5) cyc(2'b01, 0, 0, 0, $urandom, 0, 0);
    cyc(2'b01, 0, 2'b01, 0, 32'h55, 0, 0);
    chk("flush.level", 32'(level[3:0]), 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("flush.drop", rd_data[31:0], 0);
    for (int i = 0; i < 600; i++) begin
      logic [1:0] f, ce;
      f = {($urandom_range(0, 31) == 0), ($urandom_range(0, 31) == 0)};
      ce = {($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0)};
      cyc(2'($urandom), 2'($urandom), f, ce, $urandom, $urandom, $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 6; i++) cyc(2'b11, 0, 0, 0, $urandom, $urandom, 0);
    cyc(2'b11, 2'b11, 0, 0, $urandom, $urandom, 1);
    chk("rst.empty", 32'(empty), 32'h3);
    chk("rst.level", 32'(level), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
